// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types and constants for the number-guessing game logic
// Purpose: FSM state encoding, result codes and the default target magnitude bound.
// Ports: none (package).
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    PLAY = 3'd2,
    WON  = 3'd3,
    LOST = 3'd4
  } state_t;

  localparam logic [1:0] RES_OOR  = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_HIT  = 2'b11;

  localparam int RANGE_MAX_DEFAULT = 99;

endpackage

// File: rtl/guess_judge_if.sv
// rtl/guess_judge_if.sv - PRNG/player/game-status signal bundle for guess_judge
// Purpose: groups the PRNG byte, player controls and game status outputs.
// Ports (slave = judge side):
//   prn[7:0], new_game, guess_valid, guess[7:0]        into the judge
//   target[7:0], result[1:0], result_valid, tries[3:0],
//   busy, won, lost                                      out of the judge
interface guess_judge_if;
  logic [7:0] prn;
  logic       new_game;
  logic       guess_valid;
  logic [7:0] guess;
  logic [7:0] target;
  logic [1:0] result;
  logic       result_valid;
  logic [3:0] tries;
  logic       busy;
  logic       won;
  logic       lost;

  modport master (
    output prn, new_game, guess_valid, guess,
    input  target, result, result_valid, tries, busy, won, lost
  );

  modport slave (
    input  prn, new_game, guess_valid, guess,
    output target, result, result_valid, tries, busy, won, lost
  );
endinterface

// File: rtl/guess_judge_target_mapper.sv
// rtl/guess_judge_target_mapper.sv - combinational PRNG byte to signed target mapping
// Purpose: rejection-sampling front end; accepts prn in 0..2*RANGE_MAX and
//          offsets it to the signed range -RANGE_MAX..+RANGE_MAX.
// Ports:
//   prn[7:0]    in   unsigned pseudo-random byte
//   accept      out  prn is usable this cycle
//   target[7:0] out  signed target (valid only when accept)
module target_mapper
  import guess_pkg::*;
#(
  parameter int RANGE_MAX = RANGE_MAX_DEFAULT
) (
  input  logic [7:0] prn,
  output logic       accept,
  output logic [7:0] target
);

  localparam logic [8:0] SPAN = 9'(2 * RANGE_MAX);
  localparam logic [7:0] OFFS = 8'(RANGE_MAX);

  // Unsigned compare in 9 bits so SPAN values above 255 cannot wrap.
  assign accept = ({1'b0, prn} <= SPAN);

  // For every accepted prn the true difference lies in -RANGE_MAX..+RANGE_MAX,
  // which fits in 8-bit two's complement, so the modulo-256 result is exact.
  assign target = prn - OFFS;

endmodule

// File: rtl/guess_judge.sv
// rtl/guess_judge.sv - guessing-game judge: target draw, guess comparison, try counting
// Purpose: on new_game draws a signed target from the PRNG stream, then grades
//          guesses as out-of-range / too low / too high / correct until the game
//          is won or the try limit is reached.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous active-high reset
//   bus     slave modport of guess_judge_if (prn, new_game, guess_valid, guess,
//           target, result, result_valid, tries, busy, won, lost)
module guess_judge
  import guess_pkg::*;
#(
  parameter int MAX_TRIES = 7,
  parameter int RANGE_MAX = RANGE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  guess_judge_if.slave  bus
);

  localparam logic signed [8:0] LIM       = 9'(RANGE_MAX);
  localparam logic        [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  state_t      state;
  logic [7:0]  target_q;
  logic [1:0]  result_q;
  logic        result_valid_q;
  logic [3:0]  tries_q;
  logic        busy_q;
  logic        won_q;
  logic        lost_q;

  logic        map_accept;
  logic [7:0]  map_target;

  target_mapper #(.RANGE_MAX(RANGE_MAX)) u_mapper (
    .prn    (bus.prn),
    .accept (map_accept),
    .target (map_target)
  );

  // Comparator: everything widened to 9-bit signed so -128..127 guesses and
  // the +/-RANGE_MAX bounds compare without overflow.
  logic signed [8:0] guess_s;
  logic signed [8:0] target_s;
  logic              guess_oor;
  logic              guess_low;
  logic              guess_high;
  logic [3:0]        tries_inc;

  assign guess_s    = $signed({bus.guess[7], bus.guess});
  assign target_s   = $signed({target_q[7], target_q});
  assign guess_oor  = (guess_s > LIM) || (guess_s < -LIM);
  assign guess_low  = (guess_s < target_s);
  assign guess_high = (guess_s > target_s);
  assign tries_inc  = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      target_q       <= 8'd0;
      result_q       <= RES_OOR;
      result_valid_q <= 1'b0;
      tries_q        <= 4'd0;
      busy_q         <= 1'b0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      // new_game wins over everything, including a same-cycle guess.
      if (bus.new_game) begin
        state   <= DRAW;
        busy_q  <= 1'b1;
        tries_q <= 4'd0;
        won_q   <= 1'b0;
        lost_q  <= 1'b0;
      end else begin
        case (state)
          DRAW: begin
            // Rejected bytes simply retry on the next PRNG value.
            if (map_accept) begin
              target_q <= map_target;
              state    <= PLAY;
              busy_q   <= 1'b0;
            end
          end
          PLAY: begin
            if (bus.guess_valid) begin
              result_valid_q <= 1'b1;
              if (guess_oor) begin
                result_q <= RES_OOR;
              end else begin
                tries_q <= tries_inc;
                if (guess_low) begin
                  result_q <= RES_LOW;
                end else if (guess_high) begin
                  result_q <= RES_HIGH;
                end else begin
                  result_q <= RES_HIT;
                end
                // A hit takes precedence over running out of tries.
                if (!guess_low && !guess_high) begin
                  state <= WON;
                  won_q <= 1'b1;
                end else if (tries_inc == TRY_LIMIT) begin
                  state  <= LOST;
                  lost_q <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.target       = target_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.tries        = tries_q;
  assign bus.busy         = busy_q;
  assign bus.won          = won_q;
  assign bus.lost         = lost_q;

endmodule

// File: tb/tb_guess_judge.sv
// tb/tb_guess_judge.sv - self-checking bench for guess_judge
module tb_guess_judge;
  import guess_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  guess_judge_if gif ();

  guess_judge #(.MAX_TRIES(7), .RANGE_MAX(99)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ng;
    logic [7:0] prn;
    logic       gv;
    logic [7:0] guess;
    logic       e_rv;
    logic [1:0] e_res;
    logic [3:0] e_tries;
    logic       e_busy;
    logic       e_won;
    logic       e_lost;
    logic [7:0] e_target;
  } vec_t;

  vec_t       vq[$];
  logic [5:0] sb[$];

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, expv);
    end
  endtask

  function automatic void add(input logic ng, input logic [7:0] prn, input logic gv,
                              input logic [7:0] guess, input logic rv, input logic [1:0] res,
                              input logic [3:0] tries, input logic busy, input logic won,
                              input logic lost, input logic [7:0] target);
    vec_t v;
    v.ng = ng; v.prn = prn; v.gv = gv; v.guess = guess;
    v.e_rv = rv; v.e_res = res; v.e_tries = tries; v.e_busy = busy;
    v.e_won = won; v.e_lost = lost; v.e_target = target;
    vq.push_back(v);
  endfunction

  // Scoreboard consumer: every result pulse must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (gif.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", -1, 8'd1, 8'd0);
      end else begin
        logic [5:0] e;
        e = sb.pop_front();
        chk("sb_result", -1, {6'd0, gif.result}, {6'd0, e[5:4]});
        chk("sb_tries", -1, {4'd0, gif.tries}, {4'd0, e[3:0]});
      end
    end
  end

  task automatic check_outputs(input string tag, input int row, input logic rv, input logic [1:0] res,
                               input logic [3:0] tries, input logic busy, input logic won,
                               input logic lost, input logic [7:0] target);
    chk({tag, "_rv"},     row, {7'd0, gif.result_valid}, {7'd0, rv});
    chk({tag, "_result"}, row, {6'd0, gif.result}, {6'd0, res});
    chk({tag, "_tries"},  row, {4'd0, gif.tries}, {4'd0, tries});
    chk({tag, "_busy"},   row, {7'd0, gif.busy}, {7'd0, busy});
    chk({tag, "_won"},    row, {7'd0, gif.won}, {7'd0, won});
    chk({tag, "_lost"},   row, {7'd0, gif.lost}, {7'd0, lost});
    chk({tag, "_target"}, row, gif.target, target);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Game 1: prn 150 -> +51; low, high, hit; guess after win is ignored.
    add(1, 8'hFF, 0, 8'd0,   0, 2'b00, 0, 1, 0, 0, 8'h00);
    add(0, 8'd150, 0, 8'd0,  0, 2'b00, 0, 0, 0, 0, 8'h33);
    add(0, 8'hFF, 1, 8'd20,  1, 2'b01, 1, 0, 0, 0, 8'h33);
    add(0, 8'hFF, 1, 8'd80,  1, 2'b10, 2, 0, 0, 0, 8'h33);
    add(0, 8'hFF, 1, 8'd51,  1, 2'b11, 3, 0, 1, 0, 8'h33);
    add(0, 8'hFF, 1, 8'd51,  0, 2'b11, 3, 0, 1, 0, 8'h33);
    // Draw boundaries: prn 0 -> -99, prn 198 -> +99.
    add(1, 8'd0,  0, 8'd0,   0, 2'b11, 0, 1, 0, 0, 8'h33);
    add(0, 8'd0,  0, 8'd0,   0, 2'b11, 0, 0, 0, 0, 8'h9D);
    add(1, 8'hFF, 0, 8'd0,   0, 2'b11, 0, 1, 0, 0, 8'h9D);
    add(0, 8'd198, 0, 8'd0,  0, 2'b11, 0, 0, 0, 0, 8'h63);
    // Target 99: signed range-edge guesses, then win.
    add(0, 8'hFF, 1, 8'h9D,  1, 2'b01, 1, 0, 0, 0, 8'h63);
    add(0, 8'hFF, 1, 8'h81,  1, 2'b00, 1, 0, 0, 0, 8'h63);
    add(0, 8'hFF, 1, 8'h7F,  1, 2'b00, 1, 0, 0, 0, 8'h63);
    add(0, 8'hFF, 0, 8'd0,   0, 2'b00, 1, 0, 0, 0, 8'h63);
    add(0, 8'hFF, 1, 8'd99,  1, 2'b11, 2, 0, 1, 0, 8'h63);
    // Rejection sampling: 230, 255, 199 rejected, 10 -> -89.
    add(1, 8'hFF, 0, 8'd0,   0, 2'b11, 0, 1, 0, 0, 8'h63);
    add(0, 8'd230, 0, 8'd0,  0, 2'b11, 0, 1, 0, 0, 8'h63);
    add(0, 8'd255, 0, 8'd0,  0, 2'b11, 0, 1, 0, 0, 8'h63);
    add(0, 8'd199, 0, 8'd0,  0, 2'b11, 0, 1, 0, 0, 8'h63);
    add(0, 8'd10, 0, 8'd0,   0, 2'b11, 0, 0, 0, 0, 8'hA7);
    // Target 0: out-of-range guesses, then seven wrong guesses -> LOST.
    add(1, 8'hFF, 0, 8'd0,   0, 2'b11, 0, 1, 0, 0, 8'hA7);
    add(0, 8'd99, 0, 8'd0,   0, 2'b11, 0, 0, 0, 0, 8'h00);
    add(0, 8'hFF, 1, 8'd120, 1, 2'b00, 0, 0, 0, 0, 8'h00);
    add(0, 8'hFF, 1, 8'h9C,  1, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 7; i++)
      add(0, 8'hFF, 1, 8'd5, 1, 2'b10, 4'(i), 0, 0, (i == 7), 8'h00);
    add(0, 8'hFF, 1, 8'd0,   0, 2'b10, 7, 0, 0, 1, 8'h00);
    // Target 0: correct guess on the seventh (last) try still wins.
    add(1, 8'hFF, 0, 8'd0,   0, 2'b10, 0, 1, 0, 0, 8'h00);
    add(0, 8'd99, 0, 8'd0,   0, 2'b10, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 6; i++)
      add(0, 8'hFF, 1, 8'd1, 1, 2'b10, 4'(i), 0, 0, 0, 8'h00);
    add(0, 8'hFF, 1, 8'd0,   1, 2'b11, 7, 0, 1, 0, 8'h00);
    // new_game and guess on the same edge: guess dropped.
    add(1, 8'hFF, 0, 8'd0,   0, 2'b11, 0, 1, 0, 0, 8'h00);
    add(0, 8'd99, 0, 8'd0,   0, 2'b11, 0, 0, 0, 0, 8'h00);
    add(0, 8'hFF, 1, 8'd5,   1, 2'b10, 1, 0, 0, 0, 8'h00);
    add(1, 8'hFF, 1, 8'd0,   0, 2'b10, 0, 1, 0, 0, 8'h00);
    // Set up tries=4 for the mid-game reset.
    add(0, 8'd99, 0, 8'd0,   0, 2'b10, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 4; i++)
      add(0, 8'hFF, 1, 8'hFB, 1, 2'b01, 4'(i), 0, 0, 0, 8'h00);

    gif.prn = 8'hFF;
    gif.new_game = 1'b0;
    gif.guess_valid = 1'b0;
    gif.guess = 8'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_outputs("reset", 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clk);
      gif.new_game    = vq[r].ng;
      gif.prn         = vq[r].prn;
      gif.guess_valid = vq[r].gv;
      gif.guess       = vq[r].guess;
      if (vq[r].e_rv) sb.push_back({vq[r].e_res, vq[r].e_tries});
      @(posedge clk);
      #2;
      check_outputs("row", r, vq[r].e_rv, vq[r].e_res, vq[r].e_tries, vq[r].e_busy,
                    vq[r].e_won, vq[r].e_lost, vq[r].e_target);
    end

    // Asynchronous reset between edges while playing with tries=4.
    @(negedge clk);
    gif.new_game = 1'b0;
    gif.guess_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    chk("async_reset_state", 0, {5'd0, dut.state}, {5'd0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    // In IDLE a guess is ignored.
    gif.guess_valid = 1'b1;
    gif.guess = 8'd5;
    @(posedge clk);
    #2;
    check_outputs("idle_guess", 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    chk("idle_guess_state", 0, {5'd0, dut.state}, {5'd0, IDLE});
    @(negedge clk);
    gif.guess_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("sb_drained", 0, 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
